aes_key_sched_ctrl: RTL
=======================

Name: aes_key_sched_ctrl

Overview:
Sequences AES-128 key expansion and owns the round-key SRAM. It accepts a cipher key and drives a single-round key-expansion engine NR times, writing round keys 0..NR into SRAM. Once the schedule is complete, it serves round-key reads from the cipher datapath. It sits between the key-load interface and the expansion engine, SRAM and round pipeline inside aes_top.

Parameters:
KEY_S, 128, round-key / cipher-key width in bits
NR, 10, number of rounds; SRAM holds NR+1 keys
ADDR_W, 4, SRAM address width; must satisfy 2**ADDR_W > NR

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
key_valid  in  1  new cipher key offered
key_ready  out  1  controller can accept a key
key  in  KEY_S  cipher key
exp_start  out  1  one-cycle pulse: start one expansion round
exp_rk_in  out  KEY_S  previous round key presented to the engine
exp_round  out  ADDR_W  round index (1..NR) presented to the engine
exp_rk_out  in  KEY_S  next round key from the engine
exp_done  in  1  one-cycle strobe: exp_rk_out valid
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  KEY_S  SRAM write data
sram_rdata  in  KEY_S  SRAM read data, 1-cycle latency
rk_req  in  1  round-key read request
rk_addr  in  ADDR_W  requested round index
rk_gnt  out  1  request accepted this cycle
rk_valid  out  1  read data valid, one cycle after grant
rk_data  out  KEY_S  round key returned
keys_ready  out  1  full schedule resident in SRAM

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; round counter, prev-key register, keys_ready and rk_valid are 0; rk_data is 0.
  - All outputs are 0 except key_ready, which is 1 in IDLE.
  - Reset mid-expansion abandons the schedule. keys_ready stays 0 until the next full load.
- FSM states: IDLE, STORE0, EXPAND, WRITE, DONE.
- IDLE:
  - key_ready=1.
  - A key is accepted on a clk edge where key_valid=1. The controller latches key into the prev-key register, clears keys_ready and goes to STORE0.
- STORE0 (1 cycle):
  - sram_we=1, sram_addr=0, sram_wdata=prev key.
  - Sets round=1 and goes to EXPAND.
- EXPAND:
  - exp_start=1 on the first cycle only. exp_rk_in=prev key and exp_round=round are held stable throughout.
  - Stays in EXPAND until exp_done=1. On that edge it captures exp_rk_out into prev key and goes to WRITE.
  - The engine latency L>=1 is arbitrary. exp_done is ignored in every other state.
- WRITE (1 cycle):
  - sram_we=1, sram_addr=round, sram_wdata=prev key.
  - If round==NR, go to DONE. Otherwise increment round and go to EXPAND.
- DONE (1 cycle):
  - Sets keys_ready and returns to IDLE.
  - keys_ready rises exactly NR*(L+2)+2 cycles after the acceptance edge.
- key_ready=0 in every state except IDLE. key_valid is ignored while busy.
- Reads:
  - rk_gnt is combinational: rk_gnt = rk_req & keys_ready & state==IDLE & !key_valid. A key load has priority over a read in the same cycle.
  - On grant, sram_addr=rk_addr with sram_we=0.
  - On the next cycle, rk_valid=1 and rk_data=sram_rdata.
- rk_addr > NR:
  - The request is still granted, but no SRAM read is issued (sram_addr is driven to 0).
  - Next cycle, rk_valid=1 and rk_data=0.
- When no read is granted and the FSM is idle, sram_addr=0 and sram_we=0.
- A read granted in cycle N completes in N+1 even if a key is accepted in N+1. The first write happens in N+2, so there is no hazard.
- Only one SRAM access occurs per cycle by construction.

Test Plan:
1. Key load, L=1: load key 5468617473206d79204b756e67204675 with a reference engine.
   - sram[0]=5468617473206d79204b756e67204675.
   - sram[1]=e232fcf191129188b159e4e6d679a293.
   - sram[10]=28fddef86da4244accc0a4fe3b316f26.
   - keys_ready rises 32 cycles after acceptance.
   - Exactly 10 exp_start pulses with exp_round 1..10, and 11 sram_we cycles.
2. Read after load: after scenario 1, rk_req=1, rk_addr=4.
   - rk_gnt=1 the same cycle.
   - Next cycle: rk_valid=1, rk_data=a11202c9b468bea1d75157a01452495b.
   - Repeat with addr 10 → rk_data=28fddef86da4244accc0a4fe3b316f26.
3. Reads blocked during expansion, L=3:
   - rk_req is held high during expansion → rk_gnt=0 until keys_ready.
   - keys_ready rises 52 cycles after acceptance.
   - key_valid pulsed mid-expansion is ignored: sram contents are unchanged.
4. Simultaneous key load and read: in IDLE with keys_ready=1, key_valid=1 and rk_req=1 in the same cycle.
   - rk_gnt=0, the key is accepted, keys_ready=0 on the next cycle.
   - The new schedule completes correctly.
5. Reset mid-operation: drive reset=0 during round 5 EXPAND.
   - Outputs go to 0 immediately; key_ready=1, keys_ready=0.
   - Releasing reset and reloading the key from scenario 1 reproduces all 11 expected round keys.
6. Out-of-range read: rk_addr=11 after load.
   - rk_gnt=1, then rk_valid=1 with rk_data=0.
   - sram_addr stays 0 on the grant cycle.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule controller: runs the expansion engine NR times, stores
// round keys 0..NR in SRAM, then serves single-cycle-latency round-key reads.
module aes_key_sched_ctrl #(
    parameter int unsigned KEY_S  = 128,
    parameter int unsigned NR     = 10,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              key_valid_i,
    output logic              key_ready_o,
    input  logic [KEY_S-1:0]  key_i,
    output logic              exp_start_o,
    output logic [KEY_S-1:0]  exp_rk_in_o,
    output logic [ADDR_W-1:0] exp_round_o,
    input  logic [KEY_S-1:0]  exp_rk_out_i,
    input  logic              exp_done_i,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [KEY_S-1:0]  sram_wdata_o,
    input  logic [KEY_S-1:0]  sram_rdata_i,
    input  logic              rk_req_i,
    input  logic [ADDR_W-1:0] rk_addr_i,
    output logic              rk_gnt_o,
    output logic              rk_valid_o,
    output logic [KEY_S-1:0]  rk_data_o,
    output logic              keys_ready_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STORE0 = 3'd1,
        S_EXPAND = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_RND = ADDR_W'(NR);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   round_q, round_d;
    logic [KEY_S-1:0]    prev_q, prev_d;
    logic                first_q, first_d;
    logic                keys_ready_q, keys_ready_d;
    logic                rk_valid_q;
    logic                rd_hit_q;
    logic                rd_in_range;

    assign rd_in_range  = (rk_addr_i <= LAST_RND);
    assign keys_ready_o = keys_ready_q;
    assign rk_valid_o   = rk_valid_q;
    // Out-of-range reads return zero; in-range reads pass the SRAM data through.
    assign rk_data_o    = rd_hit_q ? sram_rdata_i : '0;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= S_IDLE;
            round_q      <= '0;
            prev_q       <= '0;
            first_q      <= 1'b0;
            keys_ready_q <= 1'b0;
            rk_valid_q   <= 1'b0;
            rd_hit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            prev_q       <= prev_d;
            first_q      <= first_d;
            keys_ready_q <= keys_ready_d;
            rk_valid_q   <= rk_gnt_o;
            rd_hit_q     <= rk_gnt_o & rd_in_range;
        end
    end

    always_comb begin
        state_d      = state_q;
        round_d      = round_q;
        prev_d       = prev_q;
        first_d      = 1'b0;
        keys_ready_d = keys_ready_q;
        key_ready_o  = 1'b0;
        exp_start_o  = 1'b0;
        exp_rk_in_o  = '0;
        exp_round_o  = '0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        // Key load wins over a read offered in the same cycle.
        rk_gnt_o     = rk_req_i & keys_ready_q & (state_q == S_IDLE) & ~key_valid_i;

        case (state_q)
            S_IDLE: begin
                key_ready_o = 1'b1;
                if (key_valid_i) begin
                    prev_d       = key_i;
                    keys_ready_d = 1'b0;
                    state_d      = S_STORE0;
                end else if (rk_gnt_o && rd_in_range) begin
                    sram_addr_o = rk_addr_i;
                end
            end
            S_STORE0: begin
                sram_we_o    = 1'b1;
                sram_wdata_o = prev_q;
                round_d      = ADDR_W'(1);
                first_d      = 1'b1;
                state_d      = S_EXPAND;
            end
            S_EXPAND: begin
                exp_start_o = first_q;
                exp_rk_in_o = prev_q;
                exp_round_o = round_q;
                if (exp_done_i) begin
                    prev_d  = exp_rk_out_i;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                sram_we_o    = 1'b1;
                sram_addr_o  = round_q;
                sram_wdata_o = prev_q;
                if (round_q == LAST_RND) begin
                    state_d = S_DONE;
                end else begin
                    round_d = round_q + ADDR_W'(1);
                    first_d = 1'b1;
                    state_d = S_EXPAND;
                end
            end
            S_DONE: begin
                keys_ready_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
